// File: rtl/period_people_counter.sv
// Four-period people counter: sixteen saturating 16-bit counters published on data_raw.
// Optional macro PPC_DEBOUNCE_EN inserts a per-button debouncer between synchronizer and edge detector.
module period_people_counter #(
  parameter int TICKS_PER_SEC   = 100000000,
  parameter int PERIOD_SEC      = 10,
  parameter int MAX_COUNT       = 9999,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         clear,
  input  logic [3:0]   btn,
  output logic [255:0] data_raw,
  output logic [1:0]   period_idx,
  output logic [7:0]   sec_left,
  output logic         running,
  output logic         done
);

  localparam int              PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [7:0]      SEC_LOAD   = 8'(PERIOD_SEC);
  localparam logic [15:0]     CNT_MAX    = 16'(MAX_COUNT);

  if (PERIOD_SEC < 1 || PERIOD_SEC > 255 || TICKS_PER_SEC < 1 || DEBOUNCE_CYCLES < 1 ||
      MAX_COUNT < 1 || MAX_COUNT > 65535) begin : g_param_check
    $error("period_people_counter: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [7:0]      sec_q, sec_d;
  logic [1:0]      per_q, per_d;
  logic [15:0]     cnt_q [16];
  logic [15:0]     cnt_d [16];

  logic [3:0]      sync1_q, sync1_d;
  logic [3:0]      sync2_q, sync2_d;
  logic [3:0]      prev_q, prev_d;
  logic [3:0]      lvl;
  logic [3:0]      rise;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v >= CNT_MAX) ? v : v + 16'd1;
  endfunction

  // Button input path: two-flop synchronizer, optional debounce, rising-edge detect.
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    prev_d  = lvl;
    rise    = lvl & ~prev_q;
  end

`ifdef PPC_DEBOUNCE_EN
  localparam int             DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [DW-1:0] db_cnt_q [4];
  logic [DW-1:0] db_cnt_d [4];
  logic [3:0]    filt_q, filt_d;

  // A level change is accepted only once DEBOUNCE_CYCLES differing samples arrive back to back.
  always_comb begin
    filt_d = filt_q;
    for (int b = 0; b < 4; b++) begin
      db_cnt_d[b] = '0;
      if (sync2_q[b] != filt_q[b]) begin
        if (db_cnt_q[b] == DB_LAST) begin
          filt_d[b] = sync2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      for (int b = 0; b < 4; b++) db_cnt_q[b] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int b = 0; b < 4; b++) db_cnt_q[b] <= db_cnt_d[b];
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // Session control, timer and counter update.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    sec_d   = sec_q;
    per_d   = per_q;
    for (int i = 0; i < 16; i++) cnt_d[i] = cnt_q[i];

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          presc_d = '0;
          sec_d   = SEC_LOAD;
          per_d   = 2'd0;
          for (int i = 0; i < 16; i++) cnt_d[i] = '0;
        end
      end
      S_RUN: begin
        // Edges use per_q, so an edge on the rollover cycle lands in the old period.
        for (int c = 0; c < 4; c++) begin
          if (rise[c]) begin
            cnt_d[{2'(c), per_q}] = sat_inc(cnt_q[{2'(c), per_q}]);
          end
        end
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (sec_q > 8'd1) begin
            sec_d = sec_q - 8'd1;
          end else if (per_q != 2'd3) begin
            per_d = per_q + 2'd1;
            sec_d = SEC_LOAD;
          end else begin
            state_d = S_DONE;
            sec_d   = 8'd0;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clear) begin
      state_d = S_IDLE;
      presc_d = '0;
      sec_d   = 8'd0;
      per_d   = 2'd0;
      for (int i = 0; i < 16; i++) cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      sec_q   <= 8'd0;
      per_q   <= 2'd0;
      for (int i = 0; i < 16; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      per_q   <= per_d;
      for (int i = 0; i < 16; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_pack
    assign data_raw[255-16*i -: 16] = cnt_q[i];
  end

  assign period_idx = per_q;
  assign sec_left   = sec_q;
  assign running    = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);

endmodule
